gt_victim_buffer: RTL

//  Fully-associative victim buffer downstream of the direct-mapped L1 cache.
//  It captures each line the L1 evicts on refill and answers L1-miss lookups by line address.
//  On a hit it hands the line back to the L1 for a swap.

---
 rtl/gt_victim_buffer_if.sv | 37 +++
 rtl/gt_victim_buffer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/gt_victim_buffer_if.sv
// Signal bundle between the L1 (master), the victim buffer (slave) and the memory write-back path.
// Handshakes: evict fires on an edge where evict_valid & evict_ready; write-back fires where wb_valid & wb_ready; lookup is a single-cycle pulse answered by lookup_done one cycle later.
interface gt_victim_buffer_if #(
  parameter int ENTRIES = 4,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 27
);
  localparam int OCC_W = $clog2(ENTRIES) + 1;

  logic              evict_valid;
  logic [TAG_W-1:0]  evict_tag;
  logic [LINE_W-1:0] evict_data;
  logic              evict_ready;
  logic              lookup_valid;
  logic [31:0]       lookup_addr;
  logic              lookup_done;
  logic              lookup_hit;
  logic [LINE_W-1:0] lookup_data;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [LINE_W-1:0] wb_data;
  logic              wb_ready;
  logic [OCC_W-1:0]  occupancy;
  logic              dbg_state;

  modport master (
    output evict_valid, evict_tag, evict_data, lookup_valid, lookup_addr, wb_ready,
    input  evict_ready, lookup_done, lookup_hit, lookup_data,
    input  wb_valid, wb_tag, wb_data, occupancy, dbg_state
  );

  modport slave (
    input  evict_valid, evict_tag, evict_data, lookup_valid, lookup_addr, wb_ready,
    output evict_ready, lookup_done, lookup_hit, lookup_data,
    output wb_valid, wb_tag, wb_data, occupancy, dbg_state
  );
endinterface

// File: rtl/gt_victim_buffer.sv
// Fully-associative victim buffer behind a direct-mapped L1: captures evicted lines,
// returns them on L1-miss lookups, and pushes the oldest line to memory when full.
module gt_victim_buffer #(
  parameter int ENTRIES = 4,
  parameter int LINE_W  = 256,
  parameter int TAG_W   = 27
) (
  input logic CLK,
  input logic RST_N,
  gt_victim_buffer_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int OCC_W = IDX_W + 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WB   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_d  [ENTRIES];
  logic [LINE_W-1:0] data_q [ENTRIES];
  logic [LINE_W-1:0] data_d [ENTRIES];
  logic [IDX_W-1:0]  ins_ptr_q, ins_ptr_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [LINE_W-1:0] wb_data_q, wb_data_d;
  logic              lk_done_q, lk_done_d;
  logic              lk_hit_q, lk_hit_d;
  logic [LINE_W-1:0] lk_data_q, lk_data_d;

  logic [TAG_W-1:0]  lk_tag;
  logic              lk_match, ev_match;
  logic [IDX_W-1:0]  lk_idx, ev_idx, free_idx;
  logic [OCC_W-1:0]  occ;
  logic              full, evict_ready, ev_fire;
  logic              unused_addr_bits;

  assign lk_tag           = bus.lookup_addr[31 -: TAG_W];
  assign unused_addr_bits = ^bus.lookup_addr[4:0];
  assign full             = &valid_q;
  // Ready is gated by reset so no evict or write-back can complete during a reset cycle.
  assign evict_ready      = RST_N && (state_q == ST_IDLE);
  assign ev_fire          = bus.evict_valid && evict_ready;

  always_comb begin
    lk_match = 1'b0;
    lk_idx   = '0;
    ev_match = 1'b0;
    ev_idx   = '0;
    free_idx = '0;
    occ      = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == lk_tag) begin
        lk_match = 1'b1;
        lk_idx   = IDX_W'(i);
      end
      if (valid_q[i] && tag_q[i] == bus.evict_tag) begin
        ev_match = 1'b1;
        ev_idx   = IDX_W'(i);
      end
      if (!valid_q[i]) free_idx = IDX_W'(i);
      occ = occ + OCC_W'(valid_q[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_d    = data_q;
    ins_ptr_d = ins_ptr_q;
    wb_tag_d  = wb_tag_q;
    wb_data_d = wb_data_q;
    lk_done_d = bus.lookup_valid;
    lk_hit_d  = bus.lookup_valid && lk_match;
    lk_data_d = (bus.lookup_valid && lk_match) ? data_q[lk_idx] : '0;

    // Hit invalidates first; an insert into the same slot below re-validates it.
    if (bus.lookup_valid && lk_match) valid_d[lk_idx] = 1'b0;

    if (ev_fire) begin
      if (ev_match) begin
        data_d[ev_idx]  = bus.evict_data;
        valid_d[ev_idx] = 1'b1;
      end else if (!full) begin
        tag_d[free_idx]   = bus.evict_tag;
        data_d[free_idx]  = bus.evict_data;
        valid_d[free_idx] = 1'b1;
      end else begin
        wb_tag_d           = tag_q[ins_ptr_q];
        wb_data_d          = data_q[ins_ptr_q];
        tag_d[ins_ptr_q]   = bus.evict_tag;
        data_d[ins_ptr_q]  = bus.evict_data;
        valid_d[ins_ptr_q] = 1'b1;
        ins_ptr_d          = ins_ptr_q + 1'b1;
        state_d            = ST_WB;
      end
    end

    if (state_q == ST_WB && bus.wb_ready) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      valid_q   <= '0;
      ins_ptr_q <= '0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      lk_done_q <= 1'b0;
      lk_hit_q  <= 1'b0;
      lk_data_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      ins_ptr_q <= ins_ptr_d;
      wb_tag_q  <= wb_tag_d;
      wb_data_q <= wb_data_d;
      lk_done_q <= lk_done_d;
      lk_hit_q  <= lk_hit_d;
      lk_data_q <= lk_data_d;
    end
  end

  // Line storage needs no reset; the valid bits qualify it.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.evict_ready = evict_ready;
  assign bus.lookup_done = lk_done_q;
  assign bus.lookup_hit  = lk_hit_q;
  assign bus.lookup_data = lk_data_q;
  assign bus.wb_valid    = RST_N && (state_q == ST_WB);
  assign bus.wb_tag      = wb_tag_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.occupancy   = occ;
  assign bus.dbg_state   = state_q[0];
endmodule
